// File: rtl/da_skid_decoupler_if.sv
// Decode->ALU handshake bundle: decode-side request, ALU-side response,
// flush control and the stall performance counter.
interface da_skid_decoupler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  flush;
  logic                  D_valid;
  logic                  D_ready;
  logic [DATA_WIDTH-1:0] D_dataA;
  logic [DATA_WIDTH-1:0] D_dataB;
  logic [ADDR_WIDTH-1:0] D_PC;
  logic [DATA_WIDTH-1:0] D_BranchOffset;
  logic [15:0]           D_ctrl;
  logic                  D_RF_wrd;
  logic                  D_kill;
  logic                  A_valid;
  logic                  A_ready;
  logic [DATA_WIDTH-1:0] A_dataA;
  logic [DATA_WIDTH-1:0] A_dataB;
  logic [ADDR_WIDTH-1:0] A_PC;
  logic [DATA_WIDTH-1:0] A_BranchOffset;
  logic [15:0]           A_ctrl;
  logic                  A_RF_wrd;
  logic                  A_kill;
  logic [CNT_WIDTH-1:0]  stall_count;

  modport master (
    output flush, D_valid, D_dataA, D_dataB, D_PC, D_BranchOffset, D_ctrl,
           D_RF_wrd, D_kill, A_ready,
    input  D_ready, A_valid, A_dataA, A_dataB, A_PC, A_BranchOffset, A_ctrl,
           A_RF_wrd, A_kill, stall_count
  );

  modport slave (
    input  flush, D_valid, D_dataA, D_dataB, D_PC, D_BranchOffset, D_ctrl,
           D_RF_wrd, D_kill, A_ready,
    output D_ready, A_valid, A_dataA, A_dataB, A_PC, A_BranchOffset, A_ctrl,
           A_RF_wrd, A_kill, stall_count
  );
endinterface

// File: rtl/da_skid_decoupler.sv
// Decode->ALU pipeline register with a 2-entry skid buffer so D_ready is a
// pure flop output; adds flush, kill-gating and a saturating stall counter.
module da_skid_decoupler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic             clk,
  input  logic             reset,
  da_skid_decoupler_if.slave bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] dataA;
    logic [DATA_WIDTH-1:0] dataB;
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] boff;
    logic [15:0]           ctrl;
    logic                  rf_wrd;
    logic                  kill;
  } entry_t;

  // Bit0 = OUT valid, bit1 = SKID valid, so D_ready/A_valid come straight off flops.
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b11} state_t;

  state_t               r_state, w_next;
  entry_t               r_out, r_skid, w_in;
  logic [CNT_WIDTH-1:0] r_stall;
  logic                 w_accept, w_drain;
  logic                 w_out_ld_in, w_out_ld_skid, w_skid_ld;

  assign w_accept = bus.D_valid & ~r_state[1];
  assign w_drain  = r_state[0] & bus.A_ready;

  // Killed entries keep their slot but lose RF and data-cache write side effects.
  always_comb begin
    w_in.dataA  = bus.D_dataA;
    w_in.dataB  = bus.D_dataB;
    w_in.pc     = bus.D_PC;
    w_in.boff   = bus.D_BranchOffset;
    w_in.ctrl   = {bus.D_ctrl[15:2], bus.D_ctrl[1] & ~bus.D_kill, bus.D_ctrl[0]};
    w_in.rf_wrd = bus.D_RF_wrd & ~bus.D_kill;
    w_in.kill   = bus.D_kill;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.flush) w_next = EMPTY;
    else begin
      case (r_state)
        EMPTY: if (w_accept) w_next = ONE;
        ONE: begin
          if (w_accept && !w_drain)      w_next = FULL;
          else if (!w_accept && w_drain) w_next = EMPTY;
        end
        FULL:    if (w_drain) w_next = ONE;
        default: w_next = EMPTY;
      endcase
    end
  end

  always_comb begin
    w_out_ld_in   = 1'b0;
    w_out_ld_skid = 1'b0;
    w_skid_ld     = 1'b0;
    if (!bus.flush) begin
      case (r_state)
        EMPTY: w_out_ld_in = w_accept;
        ONE: begin
          w_out_ld_in = w_accept & w_drain;
          w_skid_ld   = w_accept & ~w_drain;
        end
        FULL:    w_out_ld_skid = w_drain;
        default: ;
      endcase
    end
  end

  // Flush only clears valid state; payload is left as-is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_out_ld_in)        r_out <= w_in;
      else if (w_out_ld_skid) r_out <= r_skid;
      if (w_skid_ld)          r_skid <= w_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_stall <= '0;
    else if (r_state[0] && !bus.A_ready && !(&r_stall)) r_stall <= r_stall + 1'b1;
  end

  assign bus.D_ready        = ~r_state[1];
  assign bus.A_valid        = r_state[0];
  assign bus.A_dataA        = r_out.dataA;
  assign bus.A_dataB        = r_out.dataB;
  assign bus.A_PC           = r_out.pc;
  assign bus.A_BranchOffset = r_out.boff;
  assign bus.A_ctrl         = r_out.ctrl;
  assign bus.A_RF_wrd       = r_out.rf_wrd;
  assign bus.A_kill         = r_out.kill;
  assign bus.stall_count    = r_stall;

endmodule

// File: tb/tb_da_skid_decoupler.sv
// Directed bench: streaming, skid fill/drain, kill gating, flush, async reset
// and counter saturation on a narrow-counter second instance.
module tb_da_skid_decoupler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  da_skid_decoupler_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) bus ();
  da_skid_decoupler_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(4))  bus4 ();

  da_skid_decoupler #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  da_skid_decoupler #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [31:0] pc);
    bus.D_valid = v;
    bus.D_PC    = pc;
    bus.D_dataA = pc + 32'h1000;
  endtask

  initial begin
    bus.flush = 0; bus.D_valid = 0; bus.D_dataA = 0; bus.D_dataB = 32'hB;
    bus.D_PC = 0; bus.D_BranchOffset = 32'h44; bus.D_ctrl = 16'h0;
    bus.D_RF_wrd = 0; bus.D_kill = 0; bus.A_ready = 0;
    bus4.flush = 0; bus4.D_valid = 0; bus4.D_dataA = 0; bus4.D_dataB = 0;
    bus4.D_PC = 0; bus4.D_BranchOffset = 0; bus4.D_ctrl = 0;
    bus4.D_RF_wrd = 0; bus4.D_kill = 0; bus4.A_ready = 0;
    #12;
    chk("rst_A_valid", bus.A_valid, 0);
    chk("rst_D_ready", bus.D_ready, 1);
    chk("rst_stall",   bus.stall_count, 0);
    chk("rst_A_PC",    bus.A_PC, 0);
    chk("rst_A_ctrl",  bus.A_ctrl, 0);
    @(negedge clk); reset = 0;
    tick();

    // Streaming
    bus.A_ready = 1;
    send(1, 32'h100); tick();
    chk("st0_valid", bus.A_valid, 1); chk("st0_pc", bus.A_PC, 32'h100);
    chk("st0_dataA", bus.A_dataA, 32'h1100);
    send(1, 32'h104); tick();
    chk("st1_valid", bus.A_valid, 1); chk("st1_pc", bus.A_PC, 32'h104);
    send(1, 32'h108); tick();
    chk("st2_valid", bus.A_valid, 1); chk("st2_pc", bus.A_PC, 32'h108);
    send(0, 32'h0); tick();
    chk("st_end_valid", bus.A_valid, 0);
    chk("st_stall", bus.stall_count, 0);

    // Skid fill and ordered drain
    bus.A_ready = 0;
    send(1, 32'h200); tick();
    chk("sk0_pc", bus.A_PC, 32'h200); chk("sk0_rdy", bus.D_ready, 1);
    send(1, 32'h204); tick();
    chk("sk1_rdy", bus.D_ready, 0); chk("sk1_pc", bus.A_PC, 32'h200);
    chk("sk1_stall", bus.stall_count, 1);
    send(1, 32'h208); tick();
    chk("sk2_hold_pc", bus.A_PC, 32'h200); chk("sk2_rdy", bus.D_ready, 0);
    chk("sk2_stall", bus.stall_count, 2);
    bus.A_ready = 1; tick();
    chk("sk3_pc", bus.A_PC, 32'h204); chk("sk3_rdy", bus.D_ready, 1);
    tick();
    chk("sk4_pc", bus.A_PC, 32'h208); chk("sk4_valid", bus.A_valid, 1);
    send(0, 32'h0); tick();
    chk("sk5_valid", bus.A_valid, 0); chk("sk5_stall", bus.stall_count, 2);

    // Kill gating, then an unkilled entry for contrast
    bus.D_kill = 1; bus.D_RF_wrd = 1; bus.D_ctrl = 16'hFFFF;
    send(1, 32'h250); tick();
    chk("kill_flag", bus.A_kill, 1); chk("kill_rf", bus.A_RF_wrd, 0);
    chk("kill_ctrl", bus.A_ctrl, 16'hFFFD); chk("kill_pc", bus.A_PC, 32'h250);
    bus.D_kill = 0; bus.D_ctrl = 16'h1236;
    send(1, 32'h254); tick();
    chk("nokill_flag", bus.A_kill, 0); chk("nokill_rf", bus.A_RF_wrd, 1);
    chk("nokill_ctrl", bus.A_ctrl, 16'h1236);
    chk("nokill_boff", bus.A_BranchOffset, 32'h44);
    bus.D_RF_wrd = 0; bus.D_ctrl = 0;
    send(0, 32'h0); tick();

    // Flush in FULL with a third entry presented
    bus.A_ready = 0;
    send(1, 32'h300); tick();
    send(1, 32'h304); tick();
    chk("fl_full", bus.D_ready, 0);
    send(1, 32'h308); bus.flush = 1; tick();
    chk("fl_valid", bus.A_valid, 0); chk("fl_rdy", bus.D_ready, 1);
    chk("fl_pc_held", bus.A_PC, 32'h300);
    bus.flush = 0; send(0, 32'h0); bus.A_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl_gone", bus.A_valid, 0);
    end
    chk("fl_stall", bus.stall_count, 4);

    // Asynchronous reset while FULL
    bus.A_ready = 0;
    send(1, 32'h400); tick();
    send(1, 32'h404); tick();
    send(0, 32'h0);
    chk("ar_full", bus.D_ready, 0);
    #2 reset = 1;
    #1;
    chk("ar_valid", bus.A_valid, 0); chk("ar_stall", bus.stall_count, 0);
    chk("ar_pc", bus.A_PC, 0); chk("ar_rdy", bus.D_ready, 1);
    tick();
    chk("ar_rdy_held", bus.D_ready, 1);
    reset = 0;
    bus.A_ready = 1;
    send(1, 32'h500); tick();
    chk("ar_resume_pc", bus.A_PC, 32'h500); chk("ar_resume_v", bus.A_valid, 1);
    send(1, 32'h504); tick();
    chk("ar_resume_pc2", bus.A_PC, 32'h504);
    send(0, 32'h0); tick();
    chk("ar_resume_stall", bus.stall_count, 0);

    // Saturation on the 4-bit counter instance
    bus4.D_valid = 1; bus4.D_PC = 32'h600; tick();
    bus4.D_valid = 0;
    chk("sat_valid", bus4.A_valid, 1); chk("sat_start", bus4.stall_count, 0);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_mid", bus4.stall_count, 10);
    for (int i = 0; i < 10; i++) tick();
    chk("sat_end", bus4.stall_count, 15);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/da_skid_decoupler.md
Name:
da_skid_decoupler

Overview:
Parametrised Decode→ALU pipeline register with a valid/ready handshake and a 2-entry skid buffer. The ALU stage can stall without combinational ready paths back into decode. Adds pipeline flush, kill-gating of architectural side effects, and a saturating stall counter for performance monitoring. Sits between the decode stage and the ALU stage of the pipelined processor.

Parameters:
DATA_WIDTH, 32, width of dataA/dataB/BranchOffset
ADDR_WIDTH, 32, width of PC
CNT_WIDTH, 16, width of stall_count

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
flush  in  1  discard all held and incoming entries
D_valid  in  1  decode presents an entry
D_ready  out  1  decoupler can accept; driven directly from a register (no combinational path from A_ready)
D_dataA  in  DATA_WIDTH  operand A
D_dataB  in  DATA_WIDTH  operand B
D_PC  in  ADDR_WIDTH  instruction PC
D_BranchOffset  in  DATA_WIDTH  branch offset
D_ctrl  in  16  packed control: [15:9] opcode, [8:4] regDst, [3:2] DC_rd_wr, [1] DC_we, [0] MuxD
D_RF_wrd  in  1  register-file write enable
D_kill  in  1  entry is squashed
A_valid  out  1  ALU-side entry valid
A_ready  in  1  ALU stage consumes entry
A_dataA  out  DATA_WIDTH  operand A
A_dataB  out  DATA_WIDTH  operand B
A_PC  out  ADDR_WIDTH  PC
A_BranchOffset  out  DATA_WIDTH  branch offset
A_ctrl  out  16  packed control, same layout as D_ctrl
A_RF_wrd  out  1  RF write enable, kill-gated
A_kill  out  1  kill flag
stall_count  out  CNT_WIDTH  cycles with A_valid=1 and A_ready=0

Behaviour:
- Storage: output register (OUT, drives A_*) and skid register (SKID), each with its own valid bit. State encodings: EMPTY (none valid), ONE (OUT valid), FULL (OUT and SKID valid).
- D_ready = !SKID.valid. Accept = D_valid & D_ready. Drain = A_valid & A_ready.
- EMPTY: accept → ONE; entry is written to OUT and appears on A_* the next cycle (1-cycle latency).
- ONE: accept & drain → new entry to OUT, stay ONE. Accept & !drain → entry to SKID, go FULL. Drain & !accept → EMPTY.
- FULL: no accept (D_ready=0). Drain → SKID moves to OUT, SKID.valid cleared, go ONE. !drain → hold.
- Strict FIFO order; no entry is lost or duplicated. Back-to-back throughput is 1 entry/cycle while A_ready=1.
- Kill gating at capture: if D_kill=1, the stored RF_wrd and ctrl[1] (DC_we) are forced to 0. kill=1 and all other fields are stored unchanged. The entry still occupies a slot and handshakes normally.
- flush=1: next cycle OUT.valid=SKID.valid=0 (EMPTY), any accept that cycle is discarded, and the state goes to EMPTY whatever drain is. Payload registers keep their last values and are not cleared. D_ready=1 the cycle after flush.
- A_valid=0: payload outputs hold their last values; consumers must qualify them with A_valid.
- stall_count: +1 each cycle A_valid & !A_ready. Saturates at all-ones with no wrap. Unaffected by flush; cleared only by reset.
- reset (async, any time, including mid-transfer): A_valid=0, SKID.valid=0, all A_* payload = 0, A_ctrl=0, A_RF_wrd=0, A_kill=0, stall_count=0, D_ready=1. D_ready is asserted while reset is held.
- Simultaneous flush and reset: reset dominates; the result is identical.

Test Plan:
- Streaming: A_ready=1, send PC=0x100,0x104,0x108 on consecutive cycles → same PCs on A_PC one cycle later each, A_valid high 3 cycles, stall_count=0.
- Skid fill: A_ready=0, send PC=0x200 then 0x204 → D_ready=0 after the second accept, third entry 0x208 is held off. Raise A_ready → A_PC shows 0x200, 0x204, 0x208 in order. stall_count equals the number of stalled cycles.
- Kill: send D_kill=1, D_RF_wrd=1, D_ctrl=16'hFFFF → A_kill=1, A_RF_wrd=0, A_ctrl=16'hFFFD.
- Flush in FULL with D_valid=1 → next cycle A_valid=0, D_ready=1, and none of the three entries ever appear.
- Saturation: CNT_WIDTH=4, hold A_valid=1 and A_ready=0 for 20 cycles → stall_count stops at 15.
- Reset asserted asynchronously in FULL between clock edges → A_valid, stall_count and A_PC read 0 immediately, D_ready=1, and clean streaming resumes after release.
